// File: rtl/ctrl_id.sv
// Decode stage: registers the instruction and ALU select, flags illegal opcodes.
// Define CTRL_ID_HAZARD_EN to compile in load-use stall detection and the HOLD state.
module ctrl_id (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] i_ir_id,
   input  logic        i_valid_id,
   input  logic        i_flush,
   output logic [2:0]  o_alu_sel_r,
   output logic [15:0] o_ir_cache,
   output logic        o_stall,
   output logic        o_illegal
);

   localparam logic [3:0] OP_NOP = 4'h0;
   localparam logic [3:0] OP_ADD = 4'h1;
   localparam logic [3:0] OP_SUB = 4'h2;
   localparam logic [3:0] OP_AND = 4'h3;
   localparam logic [3:0] OP_OR  = 4'h4;
   localparam logic [3:0] OP_XOR = 4'h5;
   localparam logic [3:0] OP_SHL = 4'h6;
   localparam logic [3:0] OP_SHR = 4'h7;
   localparam logic [3:0] OP_LD  = 4'h8;
   localparam logic [3:0] OP_ST  = 4'h9;
   localparam logic [3:0] OP_BEQ = 4'hA;
   localparam logic [3:0] OP_JMP = 4'hB;

   logic [15:0] ir_q, ir_d;
   logic [2:0]  sel_q, sel_d;
   logic        illegal_q, illegal_d;

   logic [3:0] op;
   logic [2:0] sel_dec;
   logic       illegal_dec;
   logic       use_rs1;
   logic       use_rs2;
   logic       stall;
   logic       issue;

   assign op = i_ir_id[15:12];

   always_comb begin
      sel_dec     = 3'b000;
      illegal_dec = 1'b0;
      use_rs1     = 1'b0;
      use_rs2     = 1'b0;
      unique case (op)
         OP_ADD: begin sel_dec = 3'b000; use_rs1 = 1'b1; use_rs2 = 1'b1; end
         OP_SUB: begin sel_dec = 3'b001; use_rs1 = 1'b1; use_rs2 = 1'b1; end
         OP_AND: begin sel_dec = 3'b010; use_rs1 = 1'b1; use_rs2 = 1'b1; end
         OP_OR:  begin sel_dec = 3'b011; use_rs1 = 1'b1; use_rs2 = 1'b1; end
         OP_XOR: begin sel_dec = 3'b100; use_rs1 = 1'b1; use_rs2 = 1'b1; end
         OP_SHL: begin sel_dec = 3'b101; use_rs1 = 1'b1; use_rs2 = 1'b1; end
         OP_SHR: begin sel_dec = 3'b110; use_rs1 = 1'b1; use_rs2 = 1'b1; end
         OP_LD:  begin sel_dec = 3'b000; use_rs1 = 1'b1; end
         OP_ST:  begin sel_dec = 3'b000; use_rs1 = 1'b1; use_rs2 = 1'b1; end
         OP_BEQ: begin sel_dec = 3'b001; use_rs1 = 1'b1; use_rs2 = 1'b1; end
         OP_NOP, OP_JMP: sel_dec = 3'b000;
         default: illegal_dec = 1'b1;
      endcase
   end

`ifdef CTRL_ID_HAZARD_EN
   typedef enum logic {RUN, HOLD} state_e;

   state_e     state_q, state_d;
   logic       hazard;
   logic [2:0] ld_rd;
   logic [2:0] rs1;
   logic [2:0] rs2;

   assign ld_rd = ir_q[11:9];
   assign rs1   = i_ir_id[8:6];
   assign rs2   = i_ir_id[5:3];

   // Only the instruction just issued can be a load whose data is not ready yet
   always_comb begin
      hazard = (state_q == RUN) && i_valid_id &&
               (ir_q[15:12] == OP_LD) && (ld_rd != 3'd0) &&
               ((use_rs1 && (rs1 == ld_rd)) ||
                (use_rs2 && (rs2 == ld_rd)));
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= RUN;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         RUN:  if (!i_flush && hazard) state_d = HOLD;
         HOLD: state_d = RUN;
         default: state_d = RUN;
      endcase
   end

   always_comb begin
      stall = hazard && !i_flush && !rst;
   end
`else
   always_comb begin
      stall = 1'b0;
   end
`endif

   assign issue = i_valid_id && !i_flush && !stall && !illegal_dec;

   always_comb begin
      ir_d      = 16'h0000;
      sel_d     = 3'b000;
      illegal_d = i_valid_id && !i_flush && illegal_dec;
      if (issue) begin
         ir_d  = i_ir_id;
         sel_d = sel_dec;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ir_q      <= 16'h0000;
         sel_q     <= 3'b000;
         illegal_q <= 1'b0;
      end else begin
         ir_q      <= ir_d;
         sel_q     <= sel_d;
         illegal_q <= illegal_d;
      end
   end

   assign o_ir_cache  = ir_q;
   assign o_alu_sel_r = sel_q;
   assign o_illegal   = illegal_q;
   assign o_stall     = stall;

endmodule

// File: tb/tb_ctrl_id.sv
// Directed bench for ctrl_id; expectations adapt to CTRL_ID_HAZARD_EN.
module tb_ctrl_id;

`ifdef CTRL_ID_HAZARD_EN
   localparam bit HZ = 1'b1;
`else
   localparam bit HZ = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] i_ir_id;
   logic        i_valid_id;
   logic        i_flush;
   logic [2:0]  o_alu_sel_r;
   logic [15:0] o_ir_cache;
   logic        o_stall;
   logic        o_illegal;

   int pass_cnt = 0;
   int total_cnt = 0;

   ctrl_id dut (
      .clk(clk),
      .rst(rst),
      .i_ir_id(i_ir_id),
      .i_valid_id(i_valid_id),
      .i_flush(i_flush),
      .o_alu_sel_r(o_alu_sel_r),
      .o_ir_cache(o_ir_cache),
      .o_stall(o_stall),
      .o_illegal(o_illegal)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [15:0] ir, input logic v);
      i_ir_id    = ir;
      i_valid_id = v;
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; i_flush = 1'b0;
      drive(16'h0000, 1'b0);
      step();
      step();
      total_cnt++;
      if (o_stall !== 1'b0)
         $display("FAIL rst_stall got %b exp 0", o_stall);
      else pass_cnt++;
      total_cnt++;
      if (o_ir_cache !== 16'h0000 || o_alu_sel_r !== 3'b000 || o_illegal !== 1'b0)
         $display("FAIL rst_state got ir=%h sel=%b ill=%b exp 0000/000/0",
                  o_ir_cache, o_alu_sel_r, o_illegal);
      else pass_cnt++;
      rst = 1'b0;
      step();
      total_cnt++;
      if (o_ir_cache !== 16'h0000 || o_alu_sel_r !== 3'b000 || o_stall !== 1'b0)
         $display("FAIL post_rst got ir=%h sel=%b stall=%b exp 0000/000/0",
                  o_ir_cache, o_alu_sel_r, o_stall);
      else pass_cnt++;
   endtask

   task automatic test_alu();
      logic [15:0] irs [8];
      logic [2:0]  sels [8];
      irs  = '{16'h3000, 16'h4000, 16'h5000, 16'h6000,
               16'h7000, 16'hA000, 16'h9000, 16'hB000};
      sels = '{3'b010, 3'b011, 3'b100, 3'b101,
               3'b110, 3'b001, 3'b000, 3'b000};
      drive(16'h1298, 1'b1);
      step();
      total_cnt++;
      if (o_ir_cache !== 16'h1298 || o_alu_sel_r !== 3'b000)
         $display("FAIL add got ir=%h sel=%b exp 1298/000", o_ir_cache, o_alu_sel_r);
      else pass_cnt++;
      drive(16'h2298, 1'b1);
      step();
      total_cnt++;
      if (o_ir_cache !== 16'h2298 || o_alu_sel_r !== 3'b001)
         $display("FAIL sub got ir=%h sel=%b exp 2298/001", o_ir_cache, o_alu_sel_r);
      else pass_cnt++;
      for (int i = 0; i < 8; i++) begin
         drive(irs[i], 1'b1);
         step();
         total_cnt++;
         if (o_ir_cache !== irs[i] || o_alu_sel_r !== sels[i])
            $display("FAIL op_map got ir=%h sel=%b exp %h/%b",
                     o_ir_cache, o_alu_sel_r, irs[i], sels[i]);
         else pass_cnt++;
      end
      drive(16'h1298, 1'b0);
      step();
      total_cnt++;
      if (o_ir_cache !== 16'h0000 || o_alu_sel_r !== 3'b000)
         $display("FAIL bubble got ir=%h sel=%b exp 0000/000", o_ir_cache, o_alu_sel_r);
      else pass_cnt++;
   endtask

   task automatic test_load_use();
      drive(16'h8500, 1'b1);
      step();
      drive(16'h1A88, 1'b1);
      total_cnt++;
      if (o_stall !== HZ)
         $display("FAIL lu_stall got %b exp %b", o_stall, HZ);
      else pass_cnt++;
      step();
      total_cnt++;
      if (o_ir_cache !== (HZ ? 16'h0000 : 16'h1A88))
         $display("FAIL lu_first got %h exp %h", o_ir_cache, HZ ? 16'h0000 : 16'h1A88);
      else pass_cnt++;
      total_cnt++;
      if (o_stall !== 1'b0)
         $display("FAIL lu_hold_stall got %b exp 0", o_stall);
      else pass_cnt++;
      step();
      total_cnt++;
      if (o_ir_cache !== 16'h1A88)
         $display("FAIL lu_issue got %h exp 1a88", o_ir_cache);
      else pass_cnt++;
      drive(16'h0000, 1'b0);
      step();
   endtask

   task automatic test_flush();
      drive(16'h8500, 1'b1);
      step();
      i_flush = 1'b1;
      drive(16'h1A88, 1'b1);
      total_cnt++;
      if (o_stall !== 1'b0)
         $display("FAIL flush_stall got %b exp 0", o_stall);
      else pass_cnt++;
      step();
      total_cnt++;
      if (o_ir_cache !== 16'h0000 || o_illegal !== 1'b0)
         $display("FAIL flush_bubble got ir=%h ill=%b exp 0000/0", o_ir_cache, o_illegal);
      else pass_cnt++;
      i_flush = 1'b0;
      drive(16'h8500, 1'b1);
      step();
      drive(16'h1A88, 1'b1);
      total_cnt++;
      if (o_stall !== HZ)
         $display("FAIL flush_run got %b exp %b", o_stall, HZ);
      else pass_cnt++;
      step();
      step();
      drive(16'hE000, 1'b1);
      i_flush = 1'b1;
      #1;
      step();
      total_cnt++;
      if (o_illegal !== 1'b0)
         $display("FAIL flush_ill got %b exp 0", o_illegal);
      else pass_cnt++;
      i_flush = 1'b0;
   endtask

   task automatic test_illegal();
      drive(16'hF000, 1'b1);
      step();
      total_cnt++;
      if (o_ir_cache !== 16'h0000 || o_alu_sel_r !== 3'b000 || o_illegal !== 1'b1)
         $display("FAIL ill got ir=%h sel=%b ill=%b exp 0000/000/1",
                  o_ir_cache, o_alu_sel_r, o_illegal);
      else pass_cnt++;
      drive(16'h0000, 1'b0);
      step();
      total_cnt++;
      if (o_illegal !== 1'b0)
         $display("FAIL ill_pulse got %b exp 0", o_illegal);
      else pass_cnt++;
   endtask

   task automatic test_r0();
      drive(16'h8100, 1'b1);
      step();
      drive(16'h1008, 1'b1);
      total_cnt++;
      if (o_stall !== 1'b0)
         $display("FAIL r0_stall got %b exp 0", o_stall);
      else pass_cnt++;
      step();
      total_cnt++;
      if (o_ir_cache !== 16'h1008)
         $display("FAIL r0_issue got %h exp 1008", o_ir_cache);
      else pass_cnt++;
      drive(16'h8500, 1'b1);
      step();
      drive(16'h8610, 1'b1);
      total_cnt++;
      if (o_stall !== 1'b0)
         $display("FAIL ld_rs2 got %b exp 0", o_stall);
      else pass_cnt++;
      step();
      drive(16'h0000, 1'b0);
      step();
   endtask

   task automatic test_back_to_back();
      logic [15:0] seq [2];
      seq = '{16'h8A80, 16'h2148};
      drive(16'h8500, 1'b1);
      step();
      for (int i = 0; i < 2; i++) begin
         drive(seq[i], 1'b1);
         total_cnt++;
         if (o_stall !== HZ)
            $display("FAIL b2b_stall got %b exp %b", o_stall, HZ);
         else pass_cnt++;
         step();
         total_cnt++;
         if (o_ir_cache !== (HZ ? 16'h0000 : seq[i]))
            $display("FAIL b2b_first got %h exp %h", o_ir_cache, HZ ? 16'h0000 : seq[i]);
         else pass_cnt++;
         step();
         total_cnt++;
         if (o_ir_cache !== seq[i])
            $display("FAIL b2b_issue got %h exp %h", o_ir_cache, seq[i]);
         else pass_cnt++;
      end
      drive(16'h0000, 1'b0);
      step();
   endtask

   task automatic test_reset_hold();
      drive(16'h8500, 1'b1);
      step();
      drive(16'h1A88, 1'b1);
      step();
      rst = 1'b1;
      #1;
      total_cnt++;
      if (o_stall !== 1'b0)
         $display("FAIL rh_stall got %b exp 0", o_stall);
      else pass_cnt++;
      step();
      total_cnt++;
      if (o_ir_cache !== 16'h0000)
         $display("FAIL rh_drop got %h exp 0000", o_ir_cache);
      else pass_cnt++;
      rst = 1'b0;
      #1;
      step();
      total_cnt++;
      if (o_ir_cache !== 16'h1A88)
         $display("FAIL rh_reissue got %h exp 1a88", o_ir_cache);
      else pass_cnt++;
      drive(16'h0000, 1'b0);
      step();
   endtask

   initial begin
      rst = 1'b1; i_flush = 1'b0; i_ir_id = 16'h0000; i_valid_id = 1'b0;
      test_reset();
      test_alu();
      test_load_use();
      test_flush();
      test_illegal();
      test_r0();
      test_back_to_back();
      test_reset_hold();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/ctrl_id.md
CTRL_ID -- requirements
Module: ctrl_id

Interface
REQ-001 clk  input  1  clock; all state SHALL update on its rising edge.
REQ-002 rst  input  1  reset, synchronous, active-high.
REQ-003 i_ir_id  input  16  instruction presented by fetch.
REQ-004 i_valid_id  input  1  i_ir_id holds a valid instruction this cycle.
REQ-005 i_flush  input  1  taken branch or jump resolved downstream; discard the in-flight decode.
REQ-006 o_alu_sel_r  output  3  registered ALU select, consumed by the EX stage.
REQ-007 o_ir_cache  output  16  registered instruction, consumed by the EX stage.
REQ-008 o_stall  output  1  combinational; fetch SHALL hold i_ir_id and i_valid_id while this is high.
REQ-009 o_illegal  output  1  registered one-cycle pulse; an undefined opcode was decoded.

Function
REQ-010 Instruction fields SHALL be: op=[15:12], rd=[11:9], rs1=[8:6], rs2=[5:3].
REQ-011 Opcode to o_alu_sel_r mapping SHALL be:
- 0x1 ADD -> 000, 0x2 SUB -> 001, 0x3 AND -> 010, 0x4 OR -> 011
- 0x5 XOR -> 100, 0x6 SHL -> 101, 0x7 SHR -> 110
- 0x8 LD -> 000, 0x9 ST -> 000, 0xA BEQ -> 001
- 0x0 NOP -> 000, 0xB JMP -> 000
REQ-012 Opcodes 0xC-0xF SHALL issue as bubble (ir 0x0000, sel 000) and set o_illegal=1 for exactly one cycle.
REQ-013 Source usage SHALL be:
- ALU ops, ST and BEQ use rs1 and rs2.
- LD uses rs1 only.
- NOP and JMP use no sources.
REQ-014 Issue: when accepted, o_ir_cache<=i_ir_id and o_alu_sel_r<=decoded select on the next edge; latency is 1 cycle.
REQ-015 Bubble: i_valid_id=0 SHALL load o_ir_cache=0x0000 and o_alu_sel_r=000.
REQ-016 Load-use hazard: SHALL be detected when all of the following hold:
- the FSM is in RUN and i_valid_id=1;
- o_ir_cache holds LD with rd!=0;
- that rd equals a source register the incoming instruction uses.
REQ-017 On hazard detection: o_stall=1 in the same cycle, a bubble is issued, and the FSM goes RUN->HOLD.
REQ-018 In HOLD: o_stall=0, the held instruction issues without a hazard re-check, and the FSM goes HOLD->RUN.
REQ-019 Register r0 SHALL never cause a hazard.
REQ-020 i_flush=1 SHALL override everything in any state:
- bubble issued, o_stall=0, o_illegal=0;
- FSM goes to RUN.
REQ-021 Simultaneous hazard and flush SHALL resolve as flush.
REQ-022 Back-to-back LDs SHALL each be hazard-checked independently.

Reset
REQ-023 With rst=1 at a clock edge, the following SHALL hold on the next cycle:
- o_ir_cache=0x0000, o_alu_sel_r=000, o_illegal=0;
- FSM=RUN.
REQ-024 While rst=1, o_stall SHALL be 0.
REQ-025 Reset during HOLD SHALL drop the held instruction; fetch re-presents it.

Configuration
REQ-026 Macro CTRL_ID_HAZARD_EN defined: load-use detection and the HOLD state SHALL be compiled in, as REQ-016 to REQ-019.
REQ-027 Macro CTRL_ID_HAZARD_EN undefined:
- o_stall tied to 0;
- no HOLD state;
- every valid instruction issues in 1 cycle; software guarantees load-use spacing.

Verification
REQ-028 The bench SHALL cover these directed scenarios:
- rst=1 for 2 cycles then release with i_valid_id=0 -> o_ir_cache=0x0000, o_alu_sel_r=000, o_stall=0.
- i_ir_id=0x1298 (ADD r1,r2,r3) valid -> next cycle o_ir_cache=0x1298, o_alu_sel_r=000; then 0x2298 -> 0x2298, sel=001.
- 0x8500 (LD r2) then 0x1A88 (ADD r5,r2,r1) -> o_stall=1 for 1 cycle, bubble 0x0000 issued, then 0x1A88 issued (macro defined); macro undefined -> 0x1A88 issued immediately, o_stall=0.
- 0x8500 then 0x1A88 with i_flush=1 in the hazard cycle -> o_stall=0, bubble issued, FSM=RUN.
- i_ir_id=0xF000 valid -> o_ir_cache=0x0000, o_illegal=1 for exactly 1 cycle.
- 0x8100 (LD r0) then 0x1008 (ADD r0,r0,r1) -> no stall.
